mux_op_engine: RTL and testbench



---
 rtl/mux_op_pkg.sv | 19 +
 rtl/mux_op_mul_iter.sv | 64 ++++++
 rtl/mux_op_engine.sv | 180 ++++++++++++++++++
 tb/tb_mux_op_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_op_pkg.sv
// Shared types and constants for the mux_op compute engine and its multiplier.
package mux_op_pkg;

   localparam int unsigned DefaultDataW = 32;

   typedef enum logic [1:0] {
      OP_PASS_A = 2'd0,
      OP_PASS_B = 2'd1,
      OP_ADD    = 2'd2,
      OP_MUL    = 2'd3
   } op_sel_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StFinish = 2'd2
   } state_e;

endpackage

// File: rtl/mux_op_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per step, 2*DATA_W-bit accumulator.
// Only instantiated when MUX_OP_ENGINE_MUL_EN is defined.
module mux_op_mul_iter
   import mux_op_pkg::*;
#(
   parameter int unsigned DATA_W    = DefaultDataW,
   parameter int unsigned MUL_ITERS = DATA_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic [2*DATA_W-1:0]   product_o,
   output logic                  last_o
);

   localparam int unsigned CntW = $clog2(MUL_ITERS + 1);

   logic [2*DATA_W-1:0] mcand_q, mcand_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         mcand_d  = {{DATA_W{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // Asserted during the final step so the controller leaves RUN on the same edge.
   assign last_o    = step_i && (cnt_q == CntW'(MUL_ITERS - 1));
   assign product_o = acc_q;

endmodule

// File: rtl/mux_op_engine.sv
// Compute core behind the mux_operation register slave: pass A/B, add, and optional iterative
// multiply. Define MUX_OP_ENGINE_MUL_EN to build the multiplier; otherwise op 3 reports err_o.
module mux_op_engine
   import mux_op_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW
`ifdef MUX_OP_ENGINE_MUL_EN
   ,
   parameter int unsigned MUL_ITERS = DATA_W
`endif
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              start_i,
   input  logic [1:0]        op_sel_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o,
   output logic              err_o
);

   state_e              state_q, state_d;
   op_sel_e             op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                err_q, err_d;
   logic                accept;
   logic [DATA_W:0]     add_sum;

`ifdef MUX_OP_ENGINE_MUL_EN
   logic                mul_load;
   logic                mul_step;
   logic                mul_last;
   logic [2*DATA_W-1:0] mul_product;

   mux_op_mul_iter #(
      .DATA_W    (DATA_W),
      .MUL_ITERS (MUL_ITERS)
   ) u_mul (
      .clk_i     (ACLK),
      .rst_ni    (ARESETN),
      .load_i    (mul_load),
      .step_i    (mul_step),
      .a_i       (op_a_i),
      .b_i       (op_b_i),
      .product_o (mul_product),
      .last_o    (mul_last)
   );
`endif

   // State register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
`ifdef MUX_OP_ENGINE_MUL_EN
               state_d = (op_sel_i == OP_MUL) ? StRun : StFinish;
`else
               state_d = StFinish;
`endif
            end
         end
         StRun: begin
`ifdef MUX_OP_ENGINE_MUL_EN
            if (mul_last) begin
               state_d = StFinish;
            end
`else
            state_d = StIdle;
`endif
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs and control strobes.
   always_comb begin
      busy_o = (state_q != StIdle);
      accept = (state_q == StIdle) && start_i;
`ifdef MUX_OP_ENGINE_MUL_EN
      mul_load = accept && (op_sel_i == OP_MUL);
      mul_step = (state_q == StRun);
`endif
   end

   assign add_sum = {1'b0, a_q} + {1'b0, b_q};

   // Operands are captured on accept so later register writes cannot disturb a running op.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      if (accept) begin
         op_d   = op_sel_e'(op_sel_i);
         a_d    = op_a_i;
         b_d    = op_b_i;
         done_d = 1'b0;
         ovf_d  = 1'b0;
         err_d  = 1'b0;
      end
      if (state_q == StFinish) begin
         done_d = 1'b1;
         unique case (op_q)
            OP_PASS_A: begin
               result_d = a_q;
               ovf_d    = 1'b0;
            end
            OP_PASS_B: begin
               result_d = b_q;
               ovf_d    = 1'b0;
            end
            OP_ADD: begin
               result_d = add_sum[DATA_W-1:0];
               ovf_d    = add_sum[DATA_W];
            end
            OP_MUL: begin
`ifdef MUX_OP_ENGINE_MUL_EN
               result_d = mul_product[DATA_W-1:0];
               ovf_d    = |mul_product[2*DATA_W-1:DATA_W];
`else
               result_d = '0;
               ovf_d    = 1'b0;
               err_d    = 1'b1;
`endif
            end
            default: begin
               result_d = '0;
               ovf_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         op_q     <= OP_PASS_A;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign result_o = result_q;
   assign done_o   = done_q;
   assign ovf_o    = ovf_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_mux_op_engine.sv
// Self-checking bench for mux_op_engine: cycle-level behavioural model plus directed vectors.
// Follows MUX_OP_ENGINE_MUL_EN to pick the expected op 3 behaviour.
module tb_mux_op_engine;

`ifdef MUX_OP_ENGINE_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif
   localparam int MulIters = 32;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_sel_i = 2'd0;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic [31:0] result_o;
   logic        busy_o, done_o, ovf_o, err_o;

   int n_tests = 0;
   int n_fail = 0;

   always #5 ACLK = ~ACLK;

   mux_op_engine #(
      .DATA_W (32)
   ) dut (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .start_i  (start_i),
      .op_sel_i (op_sel_i),
      .op_a_i   (op_a_i),
      .op_b_i   (op_b_i),
      .result_o (result_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .ovf_o    (ovf_o),
      .err_o    (err_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: edges from accept to done, and the {err, ovf, result} the op must produce.
   function automatic int expect_lat(input logic [1:0] op);
      return (op == 2'd3 && MulEn) ? MulIters + 1 : 1;
   endfunction

   function automatic logic [33:0] expect_word(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
      logic [32:0] s;
      logic [63:0] p;
      s = {1'b0, a} + {1'b0, b};
      p = {32'd0, a} * {32'd0, b};
      case (op)
         2'd0:    return {2'b00, a};
         2'd1:    return {2'b00, b};
         2'd2:    return {1'b0, s};
         default: return MulEn ? {1'b0, |p[63:32], p[31:0]} : {2'b10, 32'd0};
      endcase
   endfunction

   int          m_left = 0;
   logic [31:0] m_res = '0;
   logic        m_done = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
   logic [33:0] m_pend = '0;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         m_left <= 0;
         m_res  <= '0;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         m_err  <= 1'b0;
      end else if (m_left == 0) begin
         if (start_i) begin
            m_left <= expect_lat(op_sel_i);
            m_pend <= expect_word(op_sel_i, op_a_i, op_b_i);
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_err  <= 1'b0;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_res  <= m_pend[31:0];
            m_ovf  <= m_pend[32];
            m_err  <= m_pend[33];
            m_done <= 1'b1;
         end
      end
   end

   always @(negedge ACLK) begin
      check("cyc_busy", {31'd0, busy_o}, {31'd0, m_left != 0});
      check("cyc_done", {31'd0, done_o}, {31'd0, m_done});
      check("cyc_result", result_o, m_res);
      check("cyc_ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
      check("cyc_err", {31'd0, err_o}, {31'd0, m_err});
      check("cyc_busy_done_excl", {31'd0, busy_o & done_o}, 32'd0);
   end

   task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge ACLK);
      #1;
      start_i  = 1'b1;
      op_sel_i = op;
      op_a_i   = a;
      op_b_i   = b;
      @(posedge ACLK);
      #1;
      start_i = 1'b0;
   endtask

   // Returns edges counted from the edge start_i was driven after.
   task automatic wait_done(input int budget, output int lat);
      int c;
      c = 1;
      while (!done_o && c < budget) begin
         @(posedge ACLK);
         #1;
         c++;
      end
      lat = c;
      if (!done_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got done_o=0 after %0d edges, expected done_o=1", c);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic exp_err, input int exp_lat);
      int lat;
      drive_start(op, a, b);
      wait_done(100, lat);
      check({name, "_result"}, result_o, exp_res);
      check({name, "_ovf"}, {31'd0, ovf_o}, {31'd0, exp_ovf});
      check({name, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
      check({name, "_latency"}, lat, exp_lat);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_result"}, result_o, 32'd0);
      check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({name, "_done"}, {31'd0, done_o}, 32'd0);
      check({name, "_ovf"}, {31'd0, ovf_o}, 32'd0);
      check({name, "_err"}, {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      repeat (2) @(posedge ACLK);
      #1;
      check_all_zero("reset");
      ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      check_all_zero("idle");

      run_op("pass_a", 2'd0, 32'h0000_0001, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 2);
      run_op("pass_b", 2'd1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
      run_op("add_carry", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0, 2);
      run_op("add_small", 2'd2, 32'd3, 32'd4, 32'h0000_0007, 1'b0, 1'b0, 2);

`ifdef MUX_OP_ENGINE_MUL_EN
      run_op("mul_6x7", 2'd3, 32'd6, 32'd7, 32'h0000_002A, 1'b0, 1'b0, 34);
      run_op("mul_ovf", 2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 34);
      run_op("mul_max", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 34);

      // Start pulses with op 1 during a multiply must be ignored.
      drive_start(2'd3, 32'd6, 32'd7);
      repeat (4) @(posedge ACLK);
      #1;
      start_i = 1'b1; op_sel_i = 2'd1; op_b_i = 32'h99;
      @(posedge ACLK);
      #1;
      start_i = 1'b0;
      repeat (12) @(posedge ACLK);
      #1;
      start_i = 1'b1; op_sel_i = 2'd1;
      @(posedge ACLK);
      #1;
      start_i = 1'b0;
      wait_done(100, lat);
      check("mul_busy_ignore_result", result_o, 32'h0000_002A);
      repeat (4) @(posedge ACLK);
      #1;
      check("mul_busy_ignore_hold", result_o, 32'h0000_002A);
      check("mul_busy_ignore_done", {31'd0, done_o}, 32'd1);

      // Reset mid-multiply: nothing partial may leak out.
      drive_start(2'd3, 32'd6, 32'd7);
      repeat (9) @(posedge ACLK);
      #1;
      ARESETN = 1'b0;
      #1;
      check_all_zero("mul_abort");
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
`else
      run_op("mul_disabled", 2'd3, 32'd6, 32'd7, 32'h0, 1'b0, 1'b1, 2);
      run_op("err_clears", 2'd0, 32'd5, 32'd0, 32'h0000_0005, 1'b0, 1'b0, 2);
      run_op("add_after_err", 2'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 2);
      ARESETN = 1'b0;
      #1;
      check_all_zero("reset_after_done");
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
`endif
      run_op("post_reset_add", 2'd2, 32'd1, 32'd1, 32'h0000_0002, 1'b0, 1'b0, 2);

      // start_i held into FINISH with a different op: second request is dropped.
      @(posedge ACLK);
      #1;
      start_i = 1'b1; op_sel_i = 2'd2; op_a_i = 32'd3; op_b_i = 32'd4;
      @(posedge ACLK);
      #1;
      op_sel_i = 2'd1; op_b_i = 32'h55;
      @(posedge ACLK);
      #1;
      start_i = 1'b0;
      check("finish_start_done", {31'd0, done_o}, 32'd1);
      check("finish_start_result", result_o, 32'h0000_0007);
      repeat (3) @(posedge ACLK);
      #1;
      check("finish_start_hold", result_o, 32'h0000_0007);
      check("finish_start_idle", {31'd0, busy_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
